// File: rtl/store_buffer_pkg.sv
// Shared types for the post-commit store buffer: access sizes, buffer entries
// and the lane helpers used by both the commit path and forwarding lookup.
package store_buffer_pkg;

    localparam int STB_DEPTH_DEFAULT = 4;

    typedef logic [31:0] bus32_t;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10
    } mem_size_t;

    typedef struct packed {
        logic [29:0] word_addr;
        bus32_t      data;
        logic [3:0]  be;
    } stb_entry_t;

    typedef enum logic {
        DRAIN_IDLE,
        DRAIN_REQ
    } drain_state_t;

    function automatic logic [3:0] size_to_be(logic [1:0] size, logic [1:0] offset);
        case (mem_size_t'(size))
            SIZE_B:  return 4'b0001 << offset;
            SIZE_H:  return 4'b0011 << offset;
            default: return 4'b1111;
        endcase
    endfunction

    // Right-aligned store data replicated so every possible lane holds the value.
    function automatic bus32_t size_to_lanes(logic [1:0] size, bus32_t data);
        case (mem_size_t'(size))
            SIZE_B:  return {4{data[7:0]}};
            SIZE_H:  return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/store_buffer_fwd_lookup.sv
// Combinational store-to-load forwarding: per-byte scan of the live entries,
// youngest entry winning each lane, yielding hit / stall / assembled data.
module stb_fwd_lookup
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = STB_DEPTH_DEFAULT,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  stb_entry_t [DEPTH-1:0] entries,
    input  logic [PTR_W-1:0]       head,
    input  logic [CNT_W-1:0]       count,
    input  logic                   ld_valid,
    input  logic [29:0]            ld_word_addr,
    input  logic [3:0]             ld_be,
    output logic                   hit,
    output logic                   stall,
    output bus32_t                 data
);

    logic [PTR_W-1:0] idx;
    logic [3:0]       covered;

    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        idx     = '0;
        covered = '0;
        data    = '0;
        // Walk oldest to youngest so a younger match overwrites an older one.
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if (ld_valid && (CNT_W'(k) < count) && (entries[idx].word_addr == ld_word_addr)) begin
                for (int b = 0; b < 4; b++) begin
                    if (ld_be[b] && entries[idx].be[b]) begin
                        covered[b]       = 1'b1;
                        data[8*b +: 8]   = entries[idx].data[8*b +: 8];
                    end
                end
            end
        end
        hit   = (covered != 4'b0000) && (covered == ld_be);
        stall = (covered != 4'b0000) && (covered != ld_be);
    end

endmodule

// File: rtl/store_buffer.sv
// Post-commit store buffer: circular FIFO of committed stores drained to data
// memory over req/gnt, with byte-accurate forwarding to loads in flight.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int STB_DEPTH = STB_DEPTH_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        commit_valid_i,
    input  logic        commit_store_i,
    input  logic [31:0] commit_addr_i,
    input  logic [31:0] commit_data_i,
    input  logic [1:0]  commit_size_i,
    output logic        commit_ready_o,
    output logic        dmem_req_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_be_o,
    input  logic        dmem_gnt_i,
    input  logic        ld_valid_i,
    input  logic [31:0] ld_addr_i,
    input  logic [1:0]  ld_size_i,
    output logic        fwd_hit_o,
    output logic [31:0] fwd_data_o,
    output logic        fwd_stall_o,
    output logic        empty_o
);

    localparam int PTR_W = $clog2(STB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    stb_entry_t [STB_DEPTH-1:0] entries_q;
    logic [PTR_W-1:0]           head_q, tail_q;
    logic [CNT_W-1:0]           count_q, count_d;
    drain_state_t               state_q, state_d;
    logic                       push, pop;

    assign commit_ready_o = (count_q != CNT_W'(STB_DEPTH));
    assign empty_o        = (count_q == '0);
    assign push           = commit_valid_i & commit_store_i & commit_ready_o;
    assign pop            = (state_q == DRAIN_REQ) & dmem_gnt_i;
    assign count_d        = count_q + CNT_W'(push) - CNT_W'(pop);

    // NOTE: entry storage carries no reset; an entry is only ever observed while
    // count covers it, so its power-up contents are irrelevant.
    always_ff @(posedge clk_i) begin
        if (push) begin
            entries_q[tail_q] <= '{word_addr: commit_addr_i[31:2],
                                   data:      size_to_lanes(commit_size_i, commit_data_i),
                                   be:        size_to_be(commit_size_i, commit_addr_i[1:0])};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= DRAIN_IDLE;
        end else begin
            if (push) tail_q <= tail_q + 1'b1;
            if (pop)  head_q <= head_q + 1'b1;
            count_q <= count_d;
            state_q <= state_d;
        end
    end

    // Leaving IDLE on the incoming count lets a store request on the very next cycle.
    always_comb begin
        state_d      = state_q;
        dmem_req_o   = 1'b0;
        dmem_addr_o  = '0;
        dmem_wdata_o = '0;
        dmem_be_o    = '0;
        case (state_q)
            DRAIN_IDLE: begin
                if (count_d != '0) state_d = DRAIN_REQ;
            end
            DRAIN_REQ: begin
                dmem_req_o   = 1'b1;
                dmem_addr_o  = {entries_q[head_q].word_addr, 2'b00};
                dmem_wdata_o = entries_q[head_q].data;
                dmem_be_o    = entries_q[head_q].be;
                if (pop && (count_d == '0)) state_d = DRAIN_IDLE;
            end
            default: state_d = DRAIN_IDLE;
        endcase
    end

    stb_fwd_lookup #(
        .DEPTH(STB_DEPTH)
    ) u_fwd_lookup (
        .entries      (entries_q),
        .head         (head_q),
        .count        (count_q),
        .ld_valid     (ld_valid_i),
        .ld_word_addr (ld_addr_i[31:2]),
        .ld_be        (size_to_be(ld_size_i, ld_addr_i[1:0])),
        .hit          (fwd_hit_o),
        .stall        (fwd_stall_o),
        .data         (fwd_data_o)
    );

endmodule
